// File: rtl/riscv_pkg.sv
// Shared load-path definitions: data width, load funct3 codes, load FSM states.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} load_state_t;

  // An access must be naturally aligned to its size; funct3=111 has no load.
  function automatic logic load_illegal(input logic [2:0] f3, input logic [2:0] off);
    case (f3)
      LB, LBU:  load_illegal = 1'b0;
      LH, LHU:  load_illegal = off[0];
      LW, LWU:  load_illegal = |off[1:0];
      LD:       load_illegal = |off;
      default:  load_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the byte/half/word/double addressed by addr_off and sign- or zero-extends it.
module load_extract
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_off,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] ext_data
);

  logic [7:0]  byte_f;
  logic [15:0] half_f;
  logic [31:0] word_f;

  always_comb begin
    byte_f = mem_rdata[{addr_off, 3'b000} +: 8];
    half_f = mem_rdata[{addr_off[2:1], 4'b0000} +: 16];
    word_f = mem_rdata[{addr_off[2], 5'b00000} +: 32];
    case (funct3)
      LB:      ext_data = {{56{byte_f[7]}}, byte_f};
      LH:      ext_data = {{48{half_f[15]}}, half_f};
      LW:      ext_data = {{32{word_f[31]}}, word_f};
      LD:      ext_data = mem_rdata;
      LBU:     ext_data = {56'd0, byte_f};
      LHU:     ext_data = {48'd0, half_f};
      LWU:     ext_data = {32'd0, word_f};
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Multi-cycle load: requests a memory doubleword, waits for rvalid with timeout,
// and captures the extended result into the memory data register.
module load_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [2:0]      addr_off,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            mem_req,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] mem_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  load_state_t     state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [2:0]      off_q;
  logic [XLEN-1:0] ext_data;

  load_extract u_extract (
    .funct3    (f3_q),
    .addr_off  (off_q),
    .mem_rdata (mem_rdata),
    .ext_data  (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      mem_out <= '0;
      mem_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f3_q  <= funct3;
            off_q <= addr_off;
            busy  <= 1'b1;
            if (load_illegal(funct3, addr_off)) begin
              state <= ERR;
              err   <= 1'b1;
            end else begin
              state   <= WAIT;
              cnt     <= '0;
              mem_req <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            mem_out <= ext_data;
            state   <= DONE;
            done    <= 1'b1;
            mem_req <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Last permitted WAIT cycle passed without data.
            state   <= ERR;
            err     <= 1'b1;
            mem_req <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
